// File: rtl/sp_abuf_arb.sv
// Autobuffer service arbiter for two SPORTs (four channels). Collects per-channel
// service requests, arbitrates them round-robin onto one memory bus and counts blocks.
module sp_abuf_arb #(
    parameter int CNTW = 14
) (
    input  logic            DSPCLK,
    input  logic            RST_,
    input  logic [3:0]      ABEN,
    input  logic [3:0]      SREQ,
    input  logic [3:0]      CNT_WE,
    input  logic [CNTW-1:0] CNT_DI,
    input  logic            BGNT,
    input  logic            BDONE,
    input  logic [3:0]      OVF_CLR,
    output logic            BREQ,
    output logic [1:0]      BCH,
    output logic            BRD,
    output logic [3:0]      PEND,
    output logic [3:0]      ABIRQ,
    output logic [3:0]      OVF
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      ptr;
    logic [1:0]      bch;
    logic [1:0]      sel;
    logic            sel_vld;
    logic [3:0]      pend;
    logic [3:0]      ovf;
    logic [3:0]      abirq;
    logic [3:0]      cand;
    logic [3:0]      sreq_ok;
    logic [3:0]      done_ch;
    logic [3:0]      active_ch;
    logic            done;
    logic            busy;
    logic [CNTW-1:0] cnt [4];
    logic [CNTW-1:0] rld [4];

    assign done    = (state == XFER) && BDONE;
    assign busy    = (state != IDLE);
    assign sreq_ok = SREQ & ABEN;

    // A channel whose enable has just dropped must not win arbitration.
    assign cand = pend & ABEN;

    always_comb begin
        logic [1:0] idx;
        sel     = ptr;
        sel_vld = 1'b0;
        idx     = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (cand[idx]) begin
                sel     = idx;
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            done_ch[i]   = done && (bch == 2'(i));
            active_ch[i] = busy && (bch == 2'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = REQ;
            REQ:     if (BGNT)    state_nxt = XFER;
            XFER:    if (BDONE)   state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge DSPCLK or negedge RST_) begin
        if (!RST_) begin
            state <= IDLE;
            ptr   <= 2'd0;
            bch   <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && sel_vld)
                bch <= sel;
            if (done)
                ptr <= bch + 2'd1;
        end
    end

    // A request landing on the completion edge of its own channel re-arms it
    // instead of counting as an overflow.
    always_ff @(posedge DSPCLK or negedge RST_) begin
        if (!RST_) begin
            pend <= 4'd0;
            ovf  <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (done_ch[i])
                    pend[i] <= sreq_ok[i];
                else if (!ABEN[i] && !active_ch[i])
                    pend[i] <= 1'b0;
                else if (sreq_ok[i])
                    pend[i] <= 1'b1;

                if (sreq_ok[i] && pend[i] && !done_ch[i])
                    ovf[i] <= 1'b1;
                else if (OVF_CLR[i])
                    ovf[i] <= 1'b0;
            end
        end
    end

    // A zero count disables block counting; a software write beats a completion.
    always_ff @(posedge DSPCLK or negedge RST_) begin
        if (!RST_) begin
            abirq <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
                rld[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                abirq[i] <= 1'b0;
                if (CNT_WE[i]) begin
                    cnt[i] <= CNT_DI;
                    rld[i] <= CNT_DI;
                end else if (done_ch[i]) begin
                    if (cnt[i] == CNTW'(1)) begin
                        cnt[i]   <= rld[i];
                        abirq[i] <= 1'b1;
                    end else if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - CNTW'(1);
                    end
                end
            end
        end
    end

    assign BREQ  = (state == REQ);
    assign BCH   = bch;
    assign BRD   = bch[0];
    assign PEND  = pend;
    assign ABIRQ = abirq;
    assign OVF   = ovf;

endmodule

// File: tb/tb_sp_abuf_arb.sv
// Bench for sp_abuf_arb: a table of per-edge vectors whose expected outputs are
// queued when driven and popped for comparison just after the clock edge.
module tb_sp_abuf_arb;

    localparam int CNTW = 14;

    typedef struct {
        bit              is_reset;
        string           name;
        logic [3:0]      aben;
        logic [3:0]      sreq;
        logic [3:0]      cnt_we;
        logic [CNTW-1:0] cnt_di;
        logic            bgnt;
        logic            bdone;
        logic [3:0]      ovf_clr;
        logic            exp_breq;
        logic [1:0]      exp_bch;
        logic [3:0]      exp_pend;
        logic [3:0]      exp_abirq;
        logic [3:0]      exp_ovf;
    } vec_t;

    logic            DSPCLK;
    logic            RST_;
    logic [3:0]      ABEN;
    logic [3:0]      SREQ;
    logic [3:0]      CNT_WE;
    logic [CNTW-1:0] CNT_DI;
    logic            BGNT;
    logic            BDONE;
    logic [3:0]      OVF_CLR;
    logic            BREQ;
    logic [1:0]      BCH;
    logic            BRD;
    logic [3:0]      PEND;
    logic [3:0]      ABIRQ;
    logic [3:0]      OVF;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests_run;
    int   tests_failed;

    sp_abuf_arb #(.CNTW(CNTW)) dut (
        .DSPCLK  (DSPCLK),
        .RST_    (RST_),
        .ABEN    (ABEN),
        .SREQ    (SREQ),
        .CNT_WE  (CNT_WE),
        .CNT_DI  (CNT_DI),
        .BGNT    (BGNT),
        .BDONE   (BDONE),
        .OVF_CLR (OVF_CLR),
        .BREQ    (BREQ),
        .BCH     (BCH),
        .BRD     (BRD),
        .PEND    (PEND),
        .ABIRQ   (ABIRQ),
        .OVF     (OVF)
    );

    initial DSPCLK = 1'b0;
    always #5 DSPCLK = ~DSPCLK;

    task automatic add(input string name, input logic [3:0] aben, input logic [3:0] sreq,
                       input logic [3:0] we, input logic [CNTW-1:0] di, input logic gnt,
                       input logic dn, input logic [3:0] clr, input logic breq,
                       input logic [1:0] bch, input logic [3:0] pend,
                       input logic [3:0] irq, input logic [3:0] ovf);
        vec_t v;
        v.is_reset  = 1'b0;
        v.name      = name;
        v.aben      = aben;
        v.sreq      = sreq;
        v.cnt_we    = we;
        v.cnt_di    = di;
        v.bgnt      = gnt;
        v.bdone     = dn;
        v.ovf_clr   = clr;
        v.exp_breq  = breq;
        v.exp_bch   = bch;
        v.exp_pend  = pend;
        v.exp_abirq = irq;
        v.exp_ovf   = ovf;
        vecs.push_back(v);
    endtask

    task automatic addReset(input string name);
        add(name, 4'h0, 4'h0, 4'h0, '0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
        vecs[vecs.size()-1].is_reset = 1'b1;
    endtask

    task automatic cmp(input string vname, input string field,
                       input logic [3:0] act, input logic [3:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h", vname, field, act, exp);
        end
    endtask

    task automatic checkOutput();
        vec_t e;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            cmp(e.name, "BREQ",  {3'b0, BREQ},  {3'b0, e.exp_breq});
            cmp(e.name, "BCH",   {2'b0, BCH},   {2'b0, e.exp_bch});
            cmp(e.name, "BRD",   {3'b0, BRD},   {3'b0, e.exp_bch[0]});
            cmp(e.name, "PEND",  PEND,          e.exp_pend);
            cmp(e.name, "ABIRQ", ABIRQ,         e.exp_abirq);
            cmp(e.name, "OVF",   OVF,           e.exp_ovf);
        end
    endtask

    task automatic driveIdle();
        ABEN    = 4'h0;
        SREQ    = 4'h0;
        CNT_WE  = 4'h0;
        CNT_DI  = '0;
        BGNT    = 1'b0;
        BDONE   = 1'b0;
        OVF_CLR = 4'h0;
    endtask

    // Reset is asserted mid-cycle and checked before any clock edge to prove it is asynchronous.
    task automatic applyStimulus(input vec_t v);
        @(negedge DSPCLK);
        if (v.is_reset) begin
            driveIdle();
            RST_ = 1'b0;
            sb.push_back(v);
            #1;
            checkOutput();
            @(posedge DSPCLK);
            @(negedge DSPCLK);
            RST_ = 1'b1;
        end else begin
            ABEN    = v.aben;
            SREQ    = v.sreq;
            CNT_WE  = v.cnt_we;
            CNT_DI  = v.cnt_di;
            BGNT    = v.bgnt;
            BDONE   = v.bdone;
            OVF_CLR = v.ovf_clr;
            sb.push_back(v);
            @(posedge DSPCLK);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST_         = 1'b0;
        driveIdle();

        // Single channel service, block counting, grant+done collision, write-beats-done.
        addReset("a_rst");
        add("a_we",       4'h1, 4'h0, 4'h1, 14'd2, 0, 0, 4'h0, 0, 2'd0, 4'h1 & 4'h0, 4'h0, 4'h0);
        add("a_sreq",     4'h1, 4'h1, 4'h0, 14'd0, 1, 1, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_breq",     4'h1, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_gnt",      4'h1, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_wait",     4'h1, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_done",     4'h1, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0, 4'h0);
        add("a_sreq2",    4'h1, 4'h1, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_breq2",    4'h1, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_gnt_done", 4'h1, 4'h0, 4'h0, 14'd0, 1, 1, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_done2",    4'h1, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h1, 4'h0);
        add("a_irq_off",  4'h1, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0, 4'h0);
        add("a_sreq3",    4'h1, 4'h1, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_breq3",    4'h1, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_gnt3",     4'h1, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_done3",    4'h1, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0, 4'h0);
        add("a_sreq4",    4'h1, 4'h1, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_breq4",    4'h1, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_gnt4",     4'h1, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_done_we",  4'h1, 4'h0, 4'h1, 14'd1, 0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0, 4'h0);
        add("a_sreq5",    4'h1, 4'h1, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_breq5",    4'h1, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_gnt5",     4'h1, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h0);
        add("a_done5",    4'h1, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h1, 4'h0);
        add("a_end",      4'h1, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0, 4'h0);

        // Round-robin across all four channels with a re-request during ch1 transfer.
        addReset("b_rst");
        add("b_sreq",   4'hF, 4'hF, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'hF, 4'h0, 4'h0);
        add("b_req0",   4'hF, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd0, 4'hF, 4'h0, 4'h0);
        add("b_gnt0",   4'hF, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd0, 4'hF, 4'h0, 4'h0);
        add("b_done0",  4'hF, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd0, 4'hE, 4'h0, 4'h0);
        add("b_req1",   4'hF, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd1, 4'hE, 4'h0, 4'h0);
        add("b_gnt1",   4'hF, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd1, 4'hE, 4'h0, 4'h0);
        add("b_resreq", 4'hF, 4'h9, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd1, 4'hF, 4'h0, 4'h8);
        add("b_done1",  4'hF, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd1, 4'hD, 4'h0, 4'h8);
        add("b_req2",   4'hF, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd2, 4'hD, 4'h0, 4'h8);
        add("b_gnt2",   4'hF, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd2, 4'hD, 4'h0, 4'h8);
        add("b_done2",  4'hF, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd2, 4'h9, 4'h0, 4'h8);
        add("b_req3",   4'hF, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd3, 4'h9, 4'h0, 4'h8);
        add("b_gnt3",   4'hF, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd3, 4'h9, 4'h0, 4'h8);
        add("b_done3",  4'hF, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd3, 4'h1, 4'h0, 4'h8);
        add("b_req0b",  4'hF, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd0, 4'h1, 4'h0, 4'h8);
        add("b_gnt0b",  4'hF, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd0, 4'h1, 4'h0, 4'h8);
        add("b_done0b", 4'hF, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0, 4'h8);
        add("b_ovfclr", 4'hF, 4'h0, 4'h0, 14'd0, 0, 0, 4'h8, 0, 2'd0, 4'h0, 4'h0, 4'h0);

        // Overflow set/clear priority and a re-request on the completion edge.
        addReset("c_rst");
        add("c_sreq",    4'h4, 4'h4, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h4, 4'h0, 4'h0);
        add("c_ovf",     4'h4, 4'h4, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd2, 4'h4, 4'h0, 4'h4);
        add("c_clr",     4'h4, 4'h0, 4'h0, 14'd0, 1, 0, 4'h4, 0, 2'd2, 4'h4, 4'h0, 4'h0);
        add("c_set_win", 4'h4, 4'h4, 4'h0, 14'd0, 0, 0, 4'h4, 0, 2'd2, 4'h4, 4'h0, 4'h4);
        add("c_clr2",    4'h4, 4'h0, 4'h0, 14'd0, 0, 0, 4'h4, 0, 2'd2, 4'h4, 4'h0, 4'h0);
        add("c_done_rq", 4'h4, 4'h4, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd2, 4'h4, 4'h0, 4'h0);
        add("c_req",     4'h4, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd2, 4'h4, 4'h0, 4'h0);
        add("c_gnt",     4'h4, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd2, 4'h4, 4'h0, 4'h0);
        add("c_done",    4'h4, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd2, 4'h0, 4'h0, 4'h0);
        add("c_idle",    4'h4, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd2, 4'h0, 4'h0, 4'h0);

        // Asynchronous reset in the middle of a ch1 transfer, then a stray BDONE.
        addReset("d_rst");
        add("d_sreq",    4'h2, 4'h2, 4'h2, 14'd1, 0, 0, 4'h0, 0, 2'd0, 4'h2, 4'h0, 4'h0);
        add("d_req",     4'h2, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd1, 4'h2, 4'h0, 4'h0);
        add("d_gnt",     4'h2, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd1, 4'h2, 4'h0, 4'h0);
        addReset("d_rst_xfer");
        add("d_late",    4'h2, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0, 4'h0);
        add("d_quiet1",  4'h2, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0, 4'h0);
        add("d_quiet2",  4'h2, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0, 4'h0);

        // Enable withdrawal while idle versus during an active transfer.
        addReset("e_rst");
        add("e_sreq3",   4'h8, 4'h8, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h8, 4'h0, 4'h0);
        add("e_drop3",   4'h0, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0, 4'h0);
        add("e_nobreq",  4'h0, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0, 4'h0);
        add("e_sreq1",   4'h2, 4'h2, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd0, 4'h2, 4'h0, 4'h0);
        add("e_req1",    4'h2, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 1, 2'd1, 4'h2, 4'h0, 4'h0);
        add("e_gnt1",    4'h2, 4'h0, 4'h0, 14'd0, 1, 0, 4'h0, 0, 2'd1, 4'h2, 4'h0, 4'h0);
        add("e_drop1",   4'h0, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd1, 4'h2, 4'h0, 4'h0);
        add("e_hold1",   4'h0, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd1, 4'h2, 4'h0, 4'h0);
        add("e_done1",   4'h0, 4'h0, 4'h0, 14'd0, 0, 1, 4'h0, 0, 2'd1, 4'h0, 4'h0, 4'h0);
        add("e_ignore",  4'h0, 4'hF, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd1, 4'h0, 4'h0, 4'h0);
        add("e_end",     4'h0, 4'h0, 4'h0, 14'd0, 0, 0, 4'h0, 0, 2'd1, 4'h0, 4'h0, 4'h0);

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i]);

        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
